// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_queue_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  localparam logic [PC_W-1:0] PC_STEP = 32'd4;

  // Instruction field positions (MSB/LSB pairs)
  localparam int OPC_MSB   = 31, OPC_LSB   = 26;
  localparam int RDST_MSB  = 25, RDST_LSB  = 21;
  localparam int RSRC1_MSB = 20, RSRC1_LSB = 16;
  localparam int RSRC2_MSB = 15, RSRC2_LSB = 11;
  localparam int SHAMT_MSB = 10, SHAMT_LSB = 6;
  localparam int FUNCT_MSB = 5,  FUNCT_LSB = 0;
  localparam int CONST_MSB = 20, CONST_LSB = 0;

  localparam logic [5:0] OPC_LI    = 6'b111_111;
  localparam logic [5:0] OPC_RTYPE = 6'b000_000;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;

  function automatic logic [5:0] get_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// DEPTH-entry FIFO of {pc, instr}; clear wins over push/pop.
module fetch_queue_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push_i,
  input  logic                           pop_i,
  input  logic                           clear_i,
  input  fq_entry_t                      wdata_i,
  output fq_entry_t                      head_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  fq_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_i && !pop_i)      cnt_d = cnt_q + 1'b1;
      else if (!push_i && pop_i) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: owns the PC, arbitrates push/pop/redirect, buffers words for decode.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic [PC_W-1:0]              imem_addr,
  input  logic [INSTR_W-1:0]           imem_rdata,
  input  logic                         redirect_valid,
  input  logic [PC_W-1:0]              redirect_pc,
  output logic                         id_valid,
  input  logic                         id_ready,
  output logic [INSTR_W-1:0]           id_instr,
  output logic [PC_W-1:0]              id_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  logic [PC_W-1:0] pc_q, pc_d;
  logic            pop, push;
  fq_entry_t       head, wdata;

  assign pop  = id_valid && id_ready;
  // A full queue still accepts a word when decode drains one the same cycle
  assign push = !redirect_valid && (!full || pop);

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid)  pc_d = {redirect_pc[PC_W-1:2], 2'b00};
    else if (push)       pc_d = pc_q + PC_STEP;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign wdata.pc    = pc_q;
  assign wdata.instr = imem_rdata;

  fetch_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (redirect_valid),
    .wdata_i (wdata),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign imem_addr = pc_q;
  assign id_valid  = !empty;
  assign id_instr  = head.instr;
  assign id_pc     = head.pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized scoreboard bench for fetch_queue, plus a PC-wrap instance.
module tb_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_ready = 1'b0;
  logic [31:0] imem_addr, imem_rdata, id_instr, id_pc;
  logic        id_valid, full, empty;
  logic [2:0]  count;

  logic [31:0] imem_addr_w, imem_rdata_w, id_instr_w, id_pc_w;
  logic        id_valid_w, full_w, empty_w;
  logic [2:0]  count_w;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h0:  return 32'hFC00_0046;
      32'h4:  return 32'hFC2B_D102;
      32'h8:  return 32'h0041_0020;
      32'hC:  return 32'h0062_0822;
      32'h10: return 32'h0083_1024;
      default: return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
    endcase
  endfunction

  assign imem_rdata   = memf(imem_addr);
  assign imem_rdata_w = memf(imem_addr_w);

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .count(count), .full(full), .empty(empty)
  );

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .reset(reset), .imem_addr(imem_addr_w), .imem_rdata(imem_rdata_w),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .id_valid(id_valid_w), .id_ready(1'b1), .id_instr(id_instr_w), .id_pc(id_pc_w),
    .count(count_w), .full(full_w), .empty(empty_w)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: queue of {pc, instr} plus the fetch PC.
  logic [63:0] mq[$];
  logic [31:0] mpc = 32'h0;

  always @(posedge clk or negedge reset) begin : model
    bit m_pop, m_push;
    logic [63:0] tmp;
    if (!reset) begin
      mq.delete();
      mpc = 32'h0;
    end else begin
      m_pop  = (mq.size() > 0) && id_ready;
      m_push = !redirect_valid && ((mq.size() < DEPTH) || m_pop);
      if (redirect_valid) begin
        mq.delete();
        mpc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (m_pop) tmp = mq.pop_front();
        if (m_push) begin
          mq.push_back({mpc, memf(mpc)});
          mpc = mpc + 32'd4;
        end
      end
    end
  end

  // Monitor: compare DUT outputs to model state away from the active edge.
  always @(negedge clk) begin : monitor
    logic [63:0] h;
    chk("id_valid", {31'b0, id_valid}, {31'b0, mq.size() > 0});
    chk("count", {29'b0, count}, mq.size());
    chk("full", {31'b0, full}, {31'b0, mq.size() == DEPTH});
    chk("empty", {31'b0, empty}, {31'b0, mq.size() == 0});
    chk("imem_addr", imem_addr, mpc);
    if (mq.size() > 0) begin
      h = mq[0];
      chk("id_pc", id_pc, h[63:32]);
      chk("id_instr", id_instr, h[31:0]);
    end
  end

  // Wrap instance: id_pc sequence after the first reset release.
  initial begin : wrap_chk
    logic [31:0] exp_pc;
    @(posedge reset);
    @(negedge clk);
    exp_pc = 32'hFFFF_FFF8;
    for (int k = 0; k < 4; k++) begin
      chk("wrap_valid", {31'b0, id_valid_w}, 32'd1);
      chk("wrap_pc", id_pc_w, exp_pc);
      chk("wrap_instr", id_instr_w, memf(exp_pc));
      exp_pc = exp_pc + 32'd4;
      @(negedge clk);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin : driver
    repeat (2) step();
    reset = 1'b1;
    // Fill with decode stalled
    repeat (6) step();
    // Drain from full with decode ready
    id_ready = 1'b1;
    repeat (10) step();
    // Build up count=3 after a redirect
    redirect_valid = 1'b1; redirect_pc = 32'h40; id_ready = 1'b0;
    step();
    redirect_valid = 1'b0;
    repeat (3) step();
    // Redirect with a simultaneous pop
    redirect_valid = 1'b1; redirect_pc = 32'h13; id_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    repeat (6) step();
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      id_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom;
      step();
    end
    // Reach count=2, then assert reset between edges
    redirect_valid = 1'b1; redirect_pc = 32'h0; id_ready = 1'b0;
    step();
    redirect_valid = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    #1;
    chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_count", {29'b0, count}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    repeat (2) step();
    reset = 1'b1;
    id_ready = 1'b1;
    repeat (8) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
